// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the ALU result, resolves BEQ/BNE and, when
// EX_MEM_OVF_TRAP_EN is defined, squashes overflowing trapping ops into a precise exception.
module ex_mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  input  logic        overflow,
  input  logic        ex_trap_ovf,
  input  logic        ex_branch,
  input  logic        ex_bne,
  input  logic [31:0] ex_br_target,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [31:0] ex_store_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        exc_valid,
  output logic [31:0] exc_epc,
  input  logic        exc_ack,
  output logic        flush_req
);

  function automatic logic branch_taken(input logic zero, input logic bne);
    return zero ^ bne;
  endfunction

  logic        accept, mem_fire, fault, in_run;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_alu_result_q, mem_alu_result_d;
  logic [31:0] mem_store_data_q, mem_store_data_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_regwrite_q, mem_regwrite_d;
  logic        mem_memread_q, mem_memread_d;
  logic        mem_memwrite_q, mem_memwrite_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;

  assign ex_ready = in_run && (!mem_valid_q || mem_ready);
  assign accept   = ex_valid && ex_ready;
  assign mem_fire = mem_valid_q && mem_ready;

`ifdef EX_MEM_OVF_TRAP_EN
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
  state_t      state_q, state_d;
  logic        exc_valid_q, exc_valid_d;
  logic        flush_req_q, flush_req_d;
  logic [31:0] exc_epc_q, exc_epc_d;

  assign in_run = (state_q == RUN);
  assign fault  = accept && ex_trap_ovf && overflow;

  always_comb begin
    state_d     = state_q;
    exc_valid_d = exc_valid_q;
    flush_req_d = flush_req_q;
    exc_epc_d   = exc_epc_q;
    if (state_q == RUN) begin
      if (fault) begin
        state_d     = TRAP;
        exc_valid_d = 1'b1;
        flush_req_d = 1'b1;
        exc_epc_d   = ex_pc;
      end
    end else if (exc_ack) begin
      state_d     = RUN;
      exc_valid_d = 1'b0;
      flush_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      exc_valid_q <= 1'b0;
      flush_req_q <= 1'b0;
      exc_epc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      exc_valid_q <= exc_valid_d;
      flush_req_q <= flush_req_d;
      exc_epc_q   <= exc_epc_d;
    end
  end

  assign exc_valid = exc_valid_q;
  assign flush_req = flush_req_q;
  assign exc_epc   = exc_epc_q;
`else
  // Trapping disabled: overflowing results wrap and are forwarded like any other.
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{ex_trap_ovf, overflow, exc_ack, ex_pc};
  assign in_run    = 1'b1;
  assign fault     = 1'b0;
  assign exc_valid = 1'b0;
  assign flush_req = 1'b0;
  assign exc_epc   = RESET_PC;
`endif

  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_regwrite_d   = mem_regwrite_q;
    mem_memread_d    = mem_memread_q;
    mem_memwrite_d   = mem_memwrite_q;
    br_taken_d       = 1'b0;
    br_target_d      = br_target_q;
    if (mem_fire) mem_valid_d = 1'b0;
    // A faulting bundle is dropped here; the slot simply drains.
    if (accept && !fault) begin
      mem_valid_d      = 1'b1;
      mem_alu_result_d = ALUResult;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
      mem_regwrite_d   = ex_regwrite && !ex_branch;
      mem_memread_d    = ex_memread && !ex_branch;
      mem_memwrite_d   = ex_memwrite && !ex_branch;
      if (ex_branch && branch_taken(Zero, ex_bne)) begin
        br_taken_d  = 1'b1;
        br_target_d = ex_br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_alu_result_q <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_regwrite_q   <= 1'b0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      br_taken_q       <= 1'b0;
      br_target_q      <= '0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_regwrite_q   <= mem_regwrite_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      br_taken_q       <= br_taken_d;
      br_target_q      <= br_target_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_regwrite   = mem_regwrite_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign br_taken       = br_taken_q;
  assign br_target      = br_target_q;

endmodule
